beep_tone: RTL

BEEP_TONE -- requirements
Module: beep_tone

---
 rtl/mintz80_pkg.sv | 15 +
 rtl/beep_tone_if.sv | 16 +
 rtl/beep_tone_strobe_sync.sv | 33 +++
 rtl/beep_tone.sv | 90 +++++++++
 4 files changed

// File: rtl/mintz80_pkg.sv
// Shared register map, state encoding and timing defaults for the mintz80 I/O blocks.
package mintz80_pkg;

  localparam logic REG_PITCH = 1'b0;
  localparam logic REG_DUR   = 1'b1;

  localparam int DEF_PRESCALE = 64;
  localparam int DEF_DUR_UNIT = 4096;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/beep_tone_if.sv
// Z80-side register bus of the beeper: decoded select, strobes and data.
interface beep_tone_if;
  import mintz80_pkg::*;

  logic       sel;
  logic       a0;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_en;

  modport master (output sel, a0, wr, rd, din, input dout, dout_en);
  modport slave  (input sel, a0, wr, rd, din, output dout, dout_en);

endinterface

// File: rtl/beep_tone_strobe_sync.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous I/O strobe.
// A strobe already high when reset releases is ignored until it has been seen low.
module strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic       s1, s2, s3;
  logic [1:0] vld;
  logic       armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1  <= strobe;
      s2  <= s1;
      s3  <= s2;
      vld <= {vld[0], 1'b1};
      // s2 holds a genuine post-reset sample only once vld[1] is set
      if (vld[1] && !s2) armed <= 1'b1;
    end
  end

  assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/beep_tone.sv
// Programmable beeper: PITCH sets the square-wave half-period, DUR plays for DUR units.
module beep_tone
  import mintz80_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int DUR_UNIT = DEF_DUR_UNIT
) (
  input  logic       clk,
  input  logic       reset,
  beep_tone_if.slave bus,
  output logic       beep,
  output logic       busy
);

  localparam int HP_W = $clog2(256 * PRESCALE);
  localparam int UN_W = $clog2(DUR_UNIT);
  localparam logic [UN_W-1:0] UNIT_LAST = UN_W'(DUR_UNIT - 1);

  state_t          state;
  logic [7:0]      pitch_r;
  logic [7:0]      dur_r;
  logic [HP_W-1:0] hp_cnt;
  logic [UN_W-1:0] unit_cnt;
  logic [HP_W-1:0] hp_reload;
  logic            commit;
  logic            unit_wrap;

  strobe_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .strobe (bus.sel & ~bus.wr),
    .rise   (commit)
  );

  assign hp_reload = HP_W'((32'(pitch_r) + 32'd1) * 32'(PRESCALE) - 32'd1);
  assign unit_wrap = (unit_cnt == UNIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pitch_r  <= 8'd0;
      dur_r    <= 8'd0;
      hp_cnt   <= '0;
      unit_cnt <= '0;
      beep     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (commit && bus.a0 == REG_PITCH) pitch_r <= bus.din;

      // a DUR commit overrides expiry and toggle on the same edge
      if (commit && bus.a0 == REG_DUR) begin
        if (bus.din == 8'd0) begin
          state <= ST_IDLE;
          beep  <= 1'b0;
          busy  <= 1'b0;
        end else begin
          dur_r    <= bus.din;
          unit_cnt <= '0;
          if (state == ST_IDLE) begin
            state  <= ST_PLAY;
            beep   <= 1'b1;
            busy   <= 1'b1;
            hp_cnt <= hp_reload;
          end
        end
      end else if (state == ST_PLAY) begin
        unit_cnt <= unit_wrap ? '0 : unit_cnt + 1'b1;
        if (unit_wrap && dur_r == 8'd1) begin
          state <= ST_IDLE;
          dur_r <= 8'd0;
          beep  <= 1'b0;
          busy  <= 1'b0;
        end else begin
          if (unit_wrap) dur_r <= dur_r - 8'd1;
          if (hp_cnt == '0) begin
            beep   <= ~beep;
            hp_cnt <= hp_reload;
          end else begin
            hp_cnt <= hp_cnt - 1'b1;
          end
        end
      end
    end
  end

  assign bus.dout_en = bus.sel & ~bus.rd;
  assign bus.dout    = !bus.dout_en        ? 8'h00 :
                       (bus.a0 == REG_DUR) ? {busy, 6'b0, beep} : pitch_r;

endmodule
